// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding and prescaler sizing.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    // Prescaler width; a 1 Hz clock still needs a one-bit counter to stay legal.
    function automatic int unsigned presc_width(input int unsigned hz);
        return (hz > 1) ? $clog2(hz) : 1;
    endfunction

endpackage

// File: rtl/countdown_timer_sec_tick_gen.sv
// One-second prescaler: counts enabled cycles and pulses sec_tick every CLK_HZ of them.
module sec_tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sec_tick
);

    localparam int unsigned    PW   = presc_width(CLK_HZ);
    localparam logic [PW-1:0]  LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        sec_tick = en && !clr && (cnt_q == LAST);
        cnt_d    = cnt_q;
        if (clr || sec_tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown for game turn limits: load/start/pause control, expiry level and pulses.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned DEFAULT_LOAD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] remaining,
    output logic             running,
    output logic             expired,
    output logic             tick,
    output logic             timeout
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             tick_q, tick_d;
    logic             timeout_q, timeout_d;

    logic presc_en;
    logic presc_clr;
    logic sec_tick;

    // The prescaler only advances on cycles that stay in RUNNING, so the
    // transition cycles into and out of PAUSED leave its count untouched.
    assign presc_en  = (state_q == ST_RUNNING) && !load && !pause;
    assign presc_clr = load || ((state_q == ST_IDLE) && start);

    sec_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_sec_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (presc_en),
        .clr     (presc_clr),
        .sec_tick(sec_tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tick_d      = 1'b0;
        timeout_d   = 1'b0;

        if (load) begin
            remaining_d = load_value;
            if (!start) begin
                state_d = ST_IDLE;
            end else if (load_value == '0) begin
                state_d   = ST_EXPIRED;
                timeout_d = 1'b1;
            end else begin
                state_d = ST_RUNNING;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (remaining_q == '0) begin
                            state_d   = ST_EXPIRED;
                            timeout_d = 1'b1;
                        end else begin
                            state_d = ST_RUNNING;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (sec_tick) begin
                        tick_d = 1'b1;
                        if (remaining_q <= WIDTH'(1)) begin
                            remaining_d = '0;
                            state_d     = ST_EXPIRED;
                            timeout_d   = 1'b1;
                        end else begin
                            remaining_d = remaining_q - 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_EXPIRED: begin
                    remaining_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUNNING);
        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= WIDTH'(DEFAULT_LOAD);
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            tick_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            running_q   <= running_d;
            expired_q   <= expired_d;
            tick_q      <= tick_d;
            timeout_q   <= timeout_d;
        end
    end

    assign remaining = remaining_q;
    assign running   = running_q;
    assign expired   = expired_q;
    assign tick      = tick_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer at CLK_HZ=10: vector table, hand-written corner sequences, random run vs model.
module tb_countdown_timer;

    localparam int HZ  = 10;
    localparam int DEF = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] load_value;
    logic       start;
    logic       pause;
    logic [3:0] remaining;
    logic       running;
    logic       expired;
    logic       tick;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    countdown_timer #(
        .CLK_HZ      (HZ),
        .WIDTH       (4),
        .DEFAULT_LOAD(DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .pause     (pause),
        .remaining (remaining),
        .running   (running),
        .expired   (expired),
        .tick      (tick),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still active, expected finish long before");
        $fatal(1);
    end

    // Reference model: a count of seconds left, a count of cycles into the
    // current second, and three mode flags (counting, frozen, done).
    int m_rem;
    int m_phase;
    bit m_run, m_frz, m_done, m_tick, m_to;

    task automatic model_reset();
        m_rem   = DEF;
        m_phase = 0;
        m_run   = 0;
        m_frz   = 0;
        m_done  = 0;
        m_tick  = 0;
        m_to    = 0;
    endtask

    task automatic model_step(input bit l, input int lv, input bit s, input bit p);
        m_tick = 0;
        m_to   = 0;
        if (l) begin
            m_rem   = lv;
            m_phase = 0;
            m_frz   = 0;
            m_run   = s && (lv != 0);
            m_done  = s && (lv == 0);
            m_to    = m_done;
        end else if (m_done) begin
            m_rem = 0;
        end else if (m_frz) begin
            if (!p) begin
                m_frz = 0;
                m_run = 1;
            end
        end else if (m_run) begin
            if (p) begin
                m_run = 0;
                m_frz = 1;
            end else begin
                m_phase++;
                if (m_phase == HZ) begin
                    m_phase = 0;
                    m_rem   = m_rem - 1;
                    m_tick  = 1;
                    if (m_rem == 0) begin
                        m_run  = 0;
                        m_done = 1;
                        m_to   = 1;
                    end
                end
            end
        end else if (s) begin
            m_phase = 0;
            if (m_rem == 0) begin
                m_done = 1;
                m_to   = 1;
            end else begin
                m_run = 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".remaining"}, remaining, m_rem);
        check({tag, ".running"},   running,   m_run);
        check({tag, ".expired"},   expired,   m_done);
        check({tag, ".tick"},      tick,      m_tick);
        check({tag, ".timeout"},   timeout,   m_to);
    endtask

    // Drive one cycle of inputs, let one edge pass, compare 1 time unit later.
    task automatic apply(input bit l, input int lv, input bit s, input bit p);
        load       = l;
        load_value = 4'(lv);
        start      = s;
        pause      = p;
        model_step(l, lv, s, p);
        @(posedge clk);
        #1;
        check_model("model");
    endtask

    task automatic reset_mid();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst.remaining", remaining, DEF);
        check("rst.running",   running,   0);
        check("rst.expired",   expired,   0);
        check("rst.tick",      tick,      0);
        check("rst.timeout",   timeout,   0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit l;
        int lv;
        bit s;
        bit p;
        int rem;
        bit run;
        bit exp;
        bit tk;
        bit to;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        load_value = '0;
        start      = 1'b0;
        pause      = 1'b0;
        model_reset();
        #2;
        check("por.remaining", remaining, DEF);
        check("por.running",   running,   0);
        check("por.expired",   expired,   0);
        check("por.tick",      tick,      0);
        check("por.timeout",   timeout,   0);
        @(negedge clk);
        rst = 1'b0;

        //           l  lv  s  p   rem run exp tk to
        tbl[0]  = '{1, 0,  0, 0,  0,  0,  0,  0, 0};
        tbl[1]  = '{0, 0,  1, 0,  0,  0,  1,  0, 1};
        tbl[2]  = '{0, 0,  0, 0,  0,  0,  1,  0, 0};
        tbl[3]  = '{0, 0,  1, 0,  0,  0,  1,  0, 0};
        tbl[4]  = '{1, 7,  0, 0,  7,  0,  0,  0, 0};
        tbl[5]  = '{1, 2,  1, 0,  2,  1,  0,  0, 0};
        tbl[6]  = '{0, 0,  0, 1,  2,  0,  0,  0, 0};
        tbl[7]  = '{0, 0,  1, 1,  2,  0,  0,  0, 0};
        tbl[8]  = '{0, 0,  0, 0,  2,  1,  0,  0, 0};
        tbl[9]  = '{0, 0,  1, 0,  2,  1,  0,  0, 0};
        tbl[10] = '{1, 0,  1, 0,  0,  0,  1,  0, 1};
        tbl[11] = '{0, 0,  0, 1,  0,  0,  1,  0, 0};
        tbl[12] = '{1, 9,  0, 0,  9,  0,  0,  0, 0};

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].l, tbl[i].lv, tbl[i].s, tbl[i].p);
            check($sformatf("vec%0d.remaining", i), remaining, tbl[i].rem);
            check($sformatf("vec%0d.running", i),   running,   tbl[i].run);
            check($sformatf("vec%0d.expired", i),   expired,   tbl[i].exp);
            check($sformatf("vec%0d.tick", i),      tick,      tbl[i].tk);
            check($sformatf("vec%0d.timeout", i),   timeout,   tbl[i].to);
        end

        // Basic countdown from 3: ticks 10, 20, 30 cycles after RUNNING entry.
        apply(1, 3, 0, 0);
        apply(0, 0, 1, 0);
        check("cd.entry_running", running, 1);
        for (int k = 1; k <= 33; k++) begin
            apply(0, 0, 0, 0);
            check($sformatf("cd.tick@%0d", k),      tick,      (k % 10 == 0 && k <= 30));
            check($sformatf("cd.remaining@%0d", k), remaining, (k >= 30) ? 0 : 3 - k / 10);
            check($sformatf("cd.expired@%0d", k),   expired,   (k >= 30));
            check($sformatf("cd.timeout@%0d", k),   timeout,   (k == 30));
            check($sformatf("cd.running@%0d", k),   running,   (k < 30));
        end

        // Pause 7 cycles with the prescaler at 4; 6 counts remain after resuming.
        apply(1, 5, 0, 0);
        apply(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) apply(0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            apply(0, 0, 0, 1);
            check("pause.remaining", remaining, 5);
            check("pause.running",   running,   0);
            check("pause.tick",      tick,      0);
        end
        for (int k = 1; k <= 8; k++) begin
            apply(0, 0, 0, 0);
            check($sformatf("resume.tick@%0d", k),      tick,      (k == 7));
            check($sformatf("resume.remaining@%0d", k), remaining, (k >= 7) ? 4 : 5);
            check($sformatf("resume.running@%0d", k),   running,   1);
        end

        // load+start while RUNNING with 2 left restarts from the new value.
        apply(1, 3, 0, 0);
        apply(0, 0, 1, 0);
        for (int k = 0; k < 13; k++) apply(0, 0, 0, 0);
        check("prio.before_remaining", remaining, 2);
        apply(1, 9, 1, 0);
        check("prio.remaining", remaining, 9);
        check("prio.running",   running,   1);
        for (int k = 1; k <= 10; k++) begin
            apply(0, 0, 0, 0);
            check($sformatf("prio.tick@%0d", k),      tick,      (k == 10));
            check($sformatf("prio.remaining@%0d", k), remaining, (k == 10) ? 8 : 9);
        end

        // Zero load then start expires on the next edge without a tick.
        apply(1, 0, 0, 0);
        apply(0, 0, 1, 0);
        check("zero.expired", expired, 1);
        check("zero.timeout", timeout, 1);
        check("zero.tick",    tick,    0);
        check("zero.running", running, 0);
        apply(0, 0, 0, 0);
        check("zero.timeout_once", timeout, 0);
        check("zero.expired_hold", expired, 1);

        // Reset with 4 seconds left, then expired lock against start.
        apply(1, 4, 0, 0);
        apply(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) apply(0, 0, 0, 0);
        check("rstrun.before_remaining", remaining, 4);
        check("rstrun.before_running",   running,   1);
        reset_mid();
        apply(0, 0, 0, 0);
        check("rstrun.idle_remaining", remaining, DEF);
        check("rstrun.idle_running",   running,   0);
        apply(1, 0, 0, 0);
        apply(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 1, k[0]);
            check("lock.expired",   expired,   1);
            check("lock.remaining", remaining, 0);
            check("lock.timeout",   timeout,   0);
            check("lock.running",   running,   0);
        end
        apply(1, 6, 0, 0);
        check("lock.release_remaining", remaining, 6);
        check("lock.release_expired",   expired,   0);

        // Random traffic against the model.
        begin
            bit p_sticky = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    reset_mid();
                end else begin
                    bit l  = ($urandom_range(0, 19) == 0);
                    int lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                         : int'($urandom_range(0, 3));
                    bit s  = ($urandom_range(0, 6) == 0);
                    if ($urandom_range(0, 9) == 0) p_sticky = !p_sticky;
                    apply(l, lv, s, p_sticky);
                    if (running && expired) check("rand.exclusive", 1, 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
